cabac_nb_line_buf: RTL and testbench
====================================

# cabac_nb_line_buf

Parametrised top-neighbour line buffer for the CABAC context engine. It stores one multi-lane word per 4x4/8x8 column position of the LCU row, for example MVD pairs, mb_type/cbp, or split/skip flags. Each lane can be written independently. Reads are forwarded from a same-cycle write to the same address, and the whole buffer can be swept to a clear value at frame start. It sits between the CABAC syntax-element binarizer (reader) and the context-update stage (writer), and replaces the fixed-width single-channel top-MVD memories.

## Interface
Parameters:
- `ADDR_W`, default 9: address width.
- `DEPTH`, default 2^ADDR_W: number of valid entries. Must satisfy DEPTH ≤ 2^ADDR_W.
- `DATA_W`, default 2*(`FMV_WIDTH`+1): bits per lane.
- `NUM_LANE`, default 1: number of independently writable lanes.
- `CLR_VAL`, default 0: per-lane value written by the clear sweep and returned for out-of-range reads.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `clr_i`, in, 1: single-cycle pulse that starts the clear sweep.
- `busy_o`, out, 1: high while the clear sweep runs.
- `r_en`, in, 1: read request.
- `r_addr`, in, ADDR_W: read address.
- `r_valid`, out, 1: `r_data` is valid this cycle.
- `r_data`, out, NUM_LANE*DATA_W: read data. Lane k occupies bits [k*DATA_W +: DATA_W].
- `w_en`, in, 1: write request.
- `w_lane_en`, in, NUM_LANE: per-lane write enable, qualified by `w_en`.
- `w_addr`, in, ADDR_W: write address.
- `w_data`, in, NUM_LANE*DATA_W: write data, same lane packing as `r_data`.

## Operation
States:
- IDLE: normal service.
- CLEAR: sweep with counter `clr_cnt`, running 0..DEPTH-1.

Transitions:
- IDLE→CLEAR when `clr_i`=1.
- CLEAR→IDLE on the cycle `clr_cnt`==DEPTH-1 is written.
- `clr_i` while in CLEAR is ignored. It does not restart the sweep.

CLEAR behaviour:
- Every lane at address `clr_cnt` is written with CLR_VAL, one address per cycle.
- User `r_en` and `w_en` are ignored: no write occurs and `r_valid` stays 0.
- `busy_o`=1 from the cycle after the `clr_i` cycle through the last sweep write.
- The sweep takes exactly DEPTH cycles.

IDLE behaviour:
- Write: lane k at `w_addr` is updated iff `w_en`=1, `w_lane_en[k]`=1 and `w_addr`<DEPTH. Writes with `w_addr`≥DEPTH are dropped silently.
- Read: a read of `r_addr`<DEPTH returns the stored word. A read of `r_addr`≥DEPTH returns CLR_VAL in every lane, with `r_valid` asserted as normal.
- Bypass: if `r_en`, `w_en`, `r_addr`==`w_addr` and the address is <DEPTH, then each lane with `w_lane_en[k]`=1 returns the new `w_data` lane. Lanes with `w_lane_en[k]`=0 return the old stored value.

Hold and reset:
- `r_data` holds its last value while `r_valid`=0.
- Reset returns the FSM to IDLE with `clr_cnt`=0.
- Reset does not initialise memory contents. They are undefined until the first completed sweep.
- Reset mid-sweep aborts the sweep. Addresses not yet swept keep undefined contents.

## Timing
- Read latency is 1: `r_en` sampled at edge N gives `r_valid`=1 and data during cycle N+1.
- Back-to-back reads run at 1 per cycle.
- A write at edge N is visible to a read issued at edge N+1 without bypass, and to a read at edge N through bypass.
- `r_valid` is a registered `r_en & ~busy`.
- Reset values: `busy_o`=0, `r_valid`=0, `r_data`=0 (output hold register and bypass-select registers cleared).
- The first user access is accepted on the cycle after `busy_o` falls.

## Structure
- Shared package `enc_defines.v` holds:
  - `FMV_WIDTH`.
  - A new `CABAC_NB_ADDR_W` default.
  - The FSM state encodings `NB_IDLE`/`NB_CLEAR`.
- The block instantiates NUM_LANE copies of the existing `rf_2p` macro via generate:
  - Port A is the read port: `cena_i`=~read.
  - Port B is the write port: `cenb_i`=`wenb_i`=~lane write.
  - `Addr_Width`=ADDR_W, `Word_Width`=DATA_W.
- Lane write, address and data are muxed between the user path and the clear sweep in front of port B.
- Per-lane bypass registers hold a match flag and a data copy. An out-of-range read flag is registered alongside them.
- No further sub-module.

## Test plan
1. Reset, then `clr_i` with DEPTH=512 → `busy_o` high for exactly 512 cycles. Afterwards, reads of addr 0, 255 and 511 return CLR_VAL=0 one cycle after `r_en`.
2. NUM_LANE=2, DATA_W=18: write addr 7 = {18'h155AA, 18'h0F0F0} with both lanes enabled, then write `w_lane_en`=2'b01 with lane0=18'h00003 → a read of addr 7 returns {18'h155AA, 18'h00003}.
3. Same-cycle read and write at addr 12 with `w_lane_en`=2'b10 and old value {A, B} → `r_data`={new lane1, B} with `r_valid`=1 next cycle.
4. DEPTH=300, ADDR_W=9: write addr 400 = 18'h3FFFF, then read 400 → CLR_VAL with `r_valid`=1. A read of addr 299 is unaffected.
5. Issue `r_en`/`w_en` and a second `clr_i` while `busy_o`=1 → no `r_valid`, no data change, and the sweep length is still DEPTH cycles.
6. Assert `rst_n`=0 for 1 cycle mid-sweep → next cycle `busy_o`=0 and `r_valid`=0. A new `clr_i` restarts the sweep from addr 0.

Source files
------------

// File: rtl/cabac_nb_line_buf_pkg.sv
// Shared definitions for the CABAC top-neighbour line buffer.
// Covers the MV width, the default address width and the sweep FSM encoding.
package cabac_nb_line_buf_pkg;

    localparam int FMV_WIDTH       = 10;
    localparam int CABAC_NB_ADDR_W = 9;

    typedef enum logic {
        NB_IDLE  = 1'b0,
        NB_CLEAR = 1'b1
    } nb_state_e;

endpackage

// File: rtl/rf_2p.sv
// Two-port register-file macro model.
// Port A is a registered read, port B is a write; chip and write enables are active low.
module rf_2p #(
    parameter int Addr_Width = 9,
    parameter int Word_Width = 22
) (
    input  logic                  clka,
    input  logic                  cena_i,
    input  logic [Addr_Width-1:0] addra_i,
    output logic [Word_Width-1:0] dataa_o,
    input  logic                  clkb,
    input  logic                  cenb_i,
    input  logic                  wenb_i,
    input  logic [Addr_Width-1:0] addrb_i,
    input  logic [Word_Width-1:0] datab_i
);

    logic [Word_Width-1:0] mem [0:(1<<Addr_Width)-1];

    // Output only moves on an enabled read, so it holds between accesses.
    always_ff @(posedge clka) begin
        if (!cena_i)
            dataa_o <= mem[addra_i];
    end

    always_ff @(posedge clkb) begin
        if (!cenb_i && !wenb_i)
            mem[addrb_i] <= datab_i;
    end

endmodule

// File: rtl/cabac_nb_line_buf.sv
// Multi-lane top-neighbour line buffer with per-lane writes, write-to-read bypass,
// out-of-range reads returning CLR_VAL and a frame-start clear sweep.
module cabac_nb_line_buf
    import cabac_nb_line_buf_pkg::*;
#(
    parameter int                ADDR_W   = CABAC_NB_ADDR_W,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter int                DATA_W   = 2 * (FMV_WIDTH + 1),
    parameter int                NUM_LANE = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    output logic                         busy_o,
    input  logic                         r_en,
    input  logic [ADDR_W-1:0]            r_addr,
    output logic                         r_valid,
    output logic [NUM_LANE*DATA_W-1:0]   r_data,
    input  logic                         w_en,
    input  logic [NUM_LANE-1:0]          w_lane_en,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [NUM_LANE*DATA_W-1:0]   w_data
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    nb_state_e                        state;
    logic [ADDR_W-1:0]                clr_cnt;
    logic                             busy;
    logic                             rd_acc;
    logic                             wr_acc;
    logic                             r_in_rng;
    logic                             w_in_rng;
    logic                             same_addr;
    logic                             oor_q;
    logic [NUM_LANE-1:0]              byp_hit;
    logic [NUM_LANE-1:0][DATA_W-1:0]  byp_data;
    logic [NUM_LANE-1:0][DATA_W-1:0]  w_word;
    logic [NUM_LANE-1:0][DATA_W-1:0]  mem_q;
    logic [NUM_LANE-1:0][DATA_W-1:0]  rd_word;
    logic [NUM_LANE*DATA_W-1:0]       hold_q;
    logic [ADDR_W-1:0]                pb_addr;

    assign busy      = (state == NB_CLEAR);
    assign busy_o    = busy;
    assign r_in_rng  = ({1'b0, r_addr} < DEPTH_L);
    assign w_in_rng  = ({1'b0, w_addr} < DEPTH_L);
    assign rd_acc    = r_en & ~busy;
    assign wr_acc    = w_en & ~busy & w_in_rng;
    assign same_addr = wr_acc & (r_addr == w_addr);
    assign w_word    = w_data;
    assign pb_addr   = busy ? clr_cnt : w_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= NB_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                NB_IDLE: begin
                    if (clr_i) begin
                        state   <= NB_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                NB_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= NB_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= NB_IDLE;
            endcase
        end
    end

    // Bypass/out-of-range selects are captured with the read so they line up with mem_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            oor_q    <= 1'b0;
            byp_hit  <= '0;
            byp_data <= '0;
            hold_q   <= '0;
        end else begin
            r_valid <= rd_acc;
            hold_q  <= r_data;
            if (rd_acc) begin
                oor_q    <= ~r_in_rng;
                byp_hit  <= {NUM_LANE{same_addr}} & w_lane_en;
                byp_data <= w_word;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        logic              lane_wr;
        logic [DATA_W-1:0] pb_data;

        assign lane_wr = busy | (wr_acc & w_lane_en[k]);
        assign pb_data = busy ? CLR_VAL : w_word[k];

        rf_2p #(
            .Addr_Width (ADDR_W),
            .Word_Width (DATA_W)
        ) u_rf (
            .clka    (clk),
            .cena_i  (~rd_acc),
            .addra_i (r_addr),
            .dataa_o (mem_q[k]),
            .clkb    (clk),
            .cenb_i  (~lane_wr),
            .wenb_i  (~lane_wr),
            .addrb_i (pb_addr),
            .datab_i (pb_data)
        );

        assign rd_word[k] = oor_q      ? CLR_VAL     :
                            byp_hit[k] ? byp_data[k] : mem_q[k];
    end

    assign r_data = r_valid ? rd_word : hold_q;

endmodule

// File: tb/tb_cabac_nb_line_buf.sv
// Directed bench for cabac_nb_line_buf: 2 lanes x 18 bits, DEPTH=300, non-zero clear value.
module tb_cabac_nb_line_buf;

    localparam int          ADDR_W = 9;
    localparam int          DEPTH  = 300;
    localparam int          DATA_W = 18;
    localparam int          NL     = 2;
    localparam logic [17:0] CV     = 18'h2A5A5;
    localparam logic [35:0] CC     = {CV, CV};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr_i = 1'b0;
    logic              busy_o;
    logic              r_en = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;
    logic              r_valid;
    logic [35:0]       r_data;
    logic              w_en = 1'b0;
    logic [NL-1:0]     w_lane_en = '0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [35:0]       w_data = '0;

    int checks = 0;
    int errors = 0;

    cabac_nb_line_buf #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .NUM_LANE (NL),
        .CLR_VAL  (CV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_i),
        .busy_o    (busy_o),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .w_en      (w_en),
        .w_lane_en (w_lane_en),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              r_en;
        logic [ADDR_W-1:0] r_addr;
        logic              w_en;
        logic [NL-1:0]     lane;
        logic [ADDR_W-1:0] w_addr;
        logic [35:0]       w_data;
        logic              exp_v;
        logic [35:0]       exp_d;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic re, input int ra, input logic we,
                                input logic [1:0] ln, input int wa, input logic [35:0] wd,
                                input logic ev, input logic [35:0] ed);
        vec_t v;
        v.r_en = re; v.r_addr = ADDR_W'(ra); v.w_en = we; v.lane = ln;
        v.w_addr = ADDR_W'(wa); v.w_data = wd; v.exp_v = ev; v.exp_d = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r_en = 1'b0; w_en = 1'b0; clr_i = 1'b0; w_lane_en = '0;
    endtask

    // Pulse clr_i and count the cycles busy_o stays high; optionally poke user
    // traffic and a second clr_i mid-sweep, counting any r_valid or r_data change.
    task automatic sweep(input bit inject, output int n, output int bad);
        logic [35:0] d0;
        clr_i = 1'b1;
        step;
        clr_i = 1'b0;
        n = 0; bad = 0; d0 = r_data;
        for (int i = 0; i < 1000 && busy_o; i++) begin
            if (r_valid || r_data !== d0) bad++;
            n++;
            if (inject && n == 10) begin
                r_en = 1'b1; r_addr = 9'd5; w_en = 1'b1; w_addr = 9'd5;
                w_lane_en = 2'b11; w_data = '1; clr_i = 1'b1;
            end else begin
                idle_inputs();
            end
            step;
        end
        idle_inputs();
    endtask

    initial begin
        int n, bad;

        // Reset state
        step; step;
        check("rst_busy", 36'(busy_o), 36'd0);
        check("rst_valid", 36'(r_valid), 36'd0);
        check("rst_data", r_data, 36'd0);
        rst_n = 1'b1;
        step;

        // Full sweep with ignored traffic and a second clr_i
        sweep(1'b1, n, bad);
        check("sweep_len", 36'(n), 36'(DEPTH));
        check("sweep_quiet", 36'(bad), 36'd0);

        vt[0]  = mk(1, 0,   0, 2'b00, 0,   '0, 1, CC);
        vt[1]  = mk(1, 299, 0, 2'b00, 0,   '0, 1, CC);
        vt[2]  = mk(1, 5,   0, 2'b00, 0,   '0, 1, CC);
        vt[3]  = mk(0, 0,   1, 2'b11, 7,   {18'h155AA, 18'h0F0F0}, 0, CC);
        vt[4]  = mk(0, 0,   1, 2'b01, 7,   {18'h3FFFF, 18'h00003}, 0, CC);
        vt[5]  = mk(1, 7,   0, 2'b00, 0,   '0, 1, {18'h155AA, 18'h00003});
        vt[6]  = mk(0, 0,   1, 2'b11, 12,  {18'h11111, 18'h22222}, 0, {18'h155AA, 18'h00003});
        vt[7]  = mk(1, 12,  1, 2'b10, 12,  {18'h33333, 18'h04444}, 1, {18'h33333, 18'h22222});
        vt[8]  = mk(1, 12,  0, 2'b00, 0,   '0, 1, {18'h33333, 18'h22222});
        vt[9]  = mk(1, 400, 1, 2'b11, 400, {18'h3FFFF, 18'h3FFFF}, 1, CC);
        vt[10] = mk(1, 299, 0, 2'b00, 0,   '0, 1, CC);
        vt[11] = mk(1, 12,  1, 2'b11, 12,  {18'h01234, 18'h05678}, 1, {18'h01234, 18'h05678});
        vt[12] = mk(1, 13,  1, 2'b11, 12,  {18'h0AAAA, 18'h0BBBB}, 1, CC);
        vt[13] = mk(1, 12,  0, 2'b00, 0,   '0, 1, {18'h0AAAA, 18'h0BBBB});
        vt[14] = mk(0, 12,  0, 2'b00, 0,   '0, 0, {18'h0AAAA, 18'h0BBBB});
        vt[15] = mk(1, 7,   1, 2'b00, 7,   {18'h3FFFF, 18'h3FFFF}, 1, {18'h155AA, 18'h00003});

        // First vector is issued on the cycle right after busy_o fell
        for (int i = 0; i < 16; i++) begin
            r_en = vt[i].r_en; r_addr = vt[i].r_addr; w_en = vt[i].w_en;
            w_lane_en = vt[i].lane; w_addr = vt[i].w_addr; w_data = vt[i].w_data;
            step;
            check($sformatf("vec%0d_valid", i), 36'(r_valid), 36'(vt[i].exp_v));
            check($sformatf("vec%0d_data", i), r_data, vt[i].exp_d);
        end
        idle_inputs();
        step;

        // Reset for one cycle mid-sweep
        clr_i = 1'b1;
        step;
        clr_i = 1'b0;
        step; step; step;
        check("mid_busy", 36'(busy_o), 36'd1);
        rst_n = 1'b0; r_en = 1'b1; r_addr = 9'd7;
        step;
        rst_n = 1'b1; r_en = 1'b0;
        check("midrst_busy", 36'(busy_o), 36'd0);
        check("midrst_valid", 36'(r_valid), 36'd0);
        check("midrst_data", r_data, 36'd0);

        // Back in normal service right away
        w_en = 1'b1; w_lane_en = 2'b11; w_addr = 9'd2; w_data = {18'h00001, 18'h00002};
        step;
        idle_inputs();
        r_en = 1'b1; r_addr = 9'd2;
        step;
        r_en = 1'b0;
        check("post_rst_rd", r_data, {18'h00001, 18'h00002});

        // Restarted sweep runs the full length and clears the word again
        sweep(1'b0, n, bad);
        check("resweep_len", 36'(n), 36'(DEPTH));
        r_en = 1'b1; r_addr = 9'd2;
        step;
        r_en = 1'b1; r_addr = 9'd0;
        check("resweep_rd2", r_data, CC);
        check("resweep_v2", 36'(r_valid), 36'd1);
        step;
        r_en = 1'b0;
        check("resweep_rd0", r_data, CC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
